pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 16-bit five-stage CPU pipeline.

---
 rtl/cpu_ctrl_pkg.sv | 21 ++
 rtl/load_use_detect.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the 16-bit five-stage CPU pipeline:
// hazard sequencer state encodings, the pipeline NOP word and shadow defaults.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_SHADOW  = 2'd2,
        ST_ILLEGAL = 2'd3
    } hz_state_t;

    // Instruction word injected into a pipeline register to squash it
    localparam logic [15:0] NOP_INSTR = 16'hE800;

    // Wrong-path fetch words still in flight after a redirect (sync imem)
    localparam int SHADOW_CYC_DEFAULT = 1;

    // Wide enough for the full 0..7 shadow range
    localparam int SHADOW_W = 3;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the instruction in decode reads a register
// that the load currently in execute has not yet written back.
// Register 0 is an ordinary register here and is compared like any other.
module load_use_detect #(
    parameter int REG_W = 3
) (
    input  logic [REG_W-1:0] DecRs,
    input  logic [REG_W-1:0] DecRt,
    input  logic             DecUsesRs,
    input  logic             DecUsesRt,
    input  logic             ExMemRead,
    input  logic [REG_W-1:0] ExRd,
    output logic             hazard
);

    logic rs_match;
    logic rt_match;

    // Compare each used source specifier against the load destination
    always_comb begin
        rs_match = DecUsesRs && (DecRs == ExRd);
        rt_match = DecUsesRt && (DecRt == ExRd);
        hazard   = ExMemRead && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline. Control outputs
// are decoded combinationally from the registered state and this cycle's
// hazard inputs; state, shadow counter and the stall statistic are registered.
module pipe_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W      = 3,
    parameter int SHADOW_CYC = SHADOW_CYC_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] DecRs,
    input  logic [REG_W-1:0] DecRt,
    input  logic             DecUsesRs,
    input  logic             DecUsesRt,
    input  logic             ExMemRead,
    input  logic [REG_W-1:0] ExRd,
    input  logic             ExBranchTaken,
    input  logic             IMemReady,
    input  logic             DMemBusy,
    input  logic             PerfClr,
    output logic             PCStall,
    output logic             FetchStall,
    output logic             FetchFlush,
    output logic             DecStall,
    output logic             DecBubble,
    output logic             ExStall,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [SHADOW_W-1:0] SHADOW_LOAD = SHADOW_W'(SHADOW_CYC);
    localparam logic [CNT_W-1:0]    CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_t           state_q;
    hz_state_t           state_d;
    logic [SHADOW_W-1:0] shadow_q;
    logic [SHADOW_W-1:0] shadow_d;
    logic                load_use;
    logic                any_ctl;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use (
        .DecRs     (DecRs),
        .DecRt     (DecRt),
        .DecUsesRs (DecUsesRs),
        .DecUsesRt (DecUsesRt),
        .ExMemRead (ExMemRead),
        .ExRd      (ExRd),
        .hazard    (load_use)
    );

    // Priority decode of control outputs, next state and next shadow count
    always_comb begin
        PCStall    = 1'b0;
        FetchStall = 1'b0;
        FetchFlush = 1'b0;
        DecStall   = 1'b0;
        DecBubble  = 1'b0;
        ExStall    = 1'b0;
        state_d    = ST_RUN;
        shadow_d   = shadow_q;

        if (DMemBusy) begin
            // Whole pipeline frozen; a pending branch stays in execute and
            // is taken on the first cycle the data memory releases.
            PCStall    = 1'b1;
            FetchStall = 1'b1;
            DecStall   = 1'b1;
            ExStall    = 1'b1;
            state_d    = ST_MEMWAIT;
        end else if (ExBranchTaken) begin
            // PC takes the branch target; squash fetch and decode.
            // A branch inside SHADOW restarts the shadow window.
            FetchFlush = 1'b1;
            DecBubble  = 1'b1;
            if (SHADOW_CYC > 0) begin
                state_d  = ST_SHADOW;
                shadow_d = SHADOW_LOAD;
            end
        end else if (state_q == ST_SHADOW) begin
            // Wrong-path words are still arriving: discard each one.
            // Decode holds a NOP, so the load-use check is irrelevant here.
            FetchFlush = 1'b1;
            if (!IMemReady) begin
                PCStall = 1'b1;
                state_d = ST_SHADOW;
            end else if (shadow_q > SHADOW_W'(1)) begin
                shadow_d = shadow_q - SHADOW_W'(1);
                state_d  = ST_SHADOW;
            end else begin
                shadow_d = '0;
            end
        end else if (load_use) begin
            // One bubble; the load moves to memory and the hazard clears
            PCStall    = 1'b1;
            FetchStall = 1'b1;
            DecBubble  = 1'b1;
        end else if (!IMemReady) begin
            // No instruction word: hold PC, let older instructions drain
            PCStall    = 1'b1;
            FetchFlush = 1'b1;
        end

        if (rst) begin
            // Keep the front end quiet and the pipe filled with NOPs in reset
            PCStall    = 1'b1;
            FetchStall = 1'b0;
            FetchFlush = 1'b1;
            DecStall   = 1'b0;
            DecBubble  = 1'b1;
            ExStall    = 1'b0;
        end
    end

    assign any_ctl = PCStall | FetchStall | FetchFlush | DecStall | DecBubble | ExStall;
    assign State   = state_q;

    // FSM state and shadow counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
        end
    end

    // Saturating count of cycles with any stall or flush active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCount <= '0;
        end else if (PerfClr) begin
            StallCount <= '0;
        end else if (any_ctl && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_ONE;
        end
    end

endmodule
